load_store_unit: RTL and testbench

//  Memory stage directly downstream of the execute ALU. Takes the ALU result (effective address or

---
 rtl/lsu_pkg.sv | 29 ++
 rtl/load_store_unit_if.sv | 21 ++
 rtl/lsu_align.sv | 58 +++++
 rtl/load_store_unit.sv | 197 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: opcodes, funct3 width codes and FSM states.
package lsu_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } lsu_state_e;

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) return f3 inside {F3_SB, F3_SH, F3_SW};
    return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory port of the load/store unit (req/gnt/rvalid protocol).
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit: store enables/replicated data, alignment flag,
// and load lane extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] store_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  output logic        misaligned,
  input  logic [1:0]  ld_addr_lo,
  input  logic [2:0]  ld_funct3,
  input  logic [31:0] rdata,
  output logic [31:0] ld_value
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_be      = '0;
    st_wdata   = '0;
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << addr_lo;
        st_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        st_be      = 4'b0011 << {addr_lo[1], 1'b0};
        st_wdata   = {2{store_data[15:0]}};
        misaligned = addr_lo[0];
      end
      default: begin
        st_be      = '1;
        st_wdata   = store_data;
        misaligned = |addr_lo;
      end
    endcase
  end

  assign ld_byte = rdata[{ld_addr_lo, 3'b000} +: 8];
  assign ld_half = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    ld_value = '0;
    case (ld_funct3)
      F3_LB:   ld_value = {{24{ld_byte[7]}}, ld_byte};
      F3_LH:   ld_value = {{16{ld_half[15]}}, ld_half};
      F3_LW:   ld_value = rdata;
      F3_LBU:  ld_value = {24'h0, ld_byte};
      F3_LHU:  ld_value = {16'h0, ld_half};
      default: ld_value = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: RV32I loads/stores over a req/gnt/rvalid port, one writeback beat per instruction.
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word accesses complete with wb_err, no memory access.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [6:0]                opcode,
  input  logic [2:0]                funct3,
  input  logic [4:0]                rd,
  input  logic [31:0]               alu_result,
  input  logic [31:0]               store_data,
  load_store_unit_if.master         mem,
  output logic                      wb_valid,
  output logic                      wb_we,
  output logic [4:0]                wb_rd,
  output logic [31:0]               wb_data,
  output logic                      wb_err
);

  lsu_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [2:0]  f3_q, f3_d;

  logic        in_ready_d, mem_req_d, mem_we_d;
  logic [31:0] mem_addr_d, mem_wdata_d;
  logic [3:0]  mem_be_d;
  logic        wb_valid_d, wb_we_d, wb_err_d;
  logic [4:0]  wb_rd_d;
  logic [31:0] wb_data_d;

  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_value;
  logic        misaligned, is_load, is_store, f3_bad, align_trap, timeout_hit;

  lsu_align u_align (
    .addr_lo    (alu_result[1:0]),
    .funct3     (funct3),
    .store_data (store_data),
    .st_be      (st_be),
    .st_wdata   (st_wdata),
    .misaligned (misaligned),
    .ld_addr_lo (addr_lo_q),
    .ld_funct3  (f3_q),
    .rdata      (mem.mem_rdata),
    .ld_value   (ld_value)
  );

  assign is_load  = (opcode == OPC_LOAD);
  assign is_store = (opcode == OPC_STORE);
  assign f3_bad   = (is_load || is_store) && !f3_legal(is_store, funct3);

`ifdef LSU_MISALIGN_TRAP_EN
  assign align_trap = misaligned;
`else
  logic unused_misaligned;
  assign unused_misaligned = misaligned;
  assign align_trap        = 1'b0;
`endif

  // >= rather than ==: a grant on the final REQ cycle leaves WAIT one rvalid chance before giving up
  assign timeout_hit = (cnt_q >= 16'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_lo_d   = addr_lo_q;
    f3_d        = f3_q;
    in_ready_d  = in_ready;
    mem_req_d   = mem.mem_req;
    mem_we_d    = mem.mem_we;
    mem_addr_d  = mem.mem_addr;
    mem_wdata_d = mem.mem_wdata;
    mem_be_d    = mem.mem_be;
    wb_valid_d  = 1'b0;
    wb_we_d     = 1'b0;
    wb_err_d    = 1'b0;
    wb_rd_d     = wb_rd;
    wb_data_d   = wb_data;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          in_ready_d = 1'b0;
          wb_rd_d    = rd;
          addr_lo_d  = alu_result[1:0];
          f3_d       = funct3;
          if ((is_load || is_store) && !f3_bad && !align_trap) begin
            state_d     = REQ;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store;
            mem_addr_d  = {alu_result[31:2], 2'b00};
            mem_be_d    = is_store ? st_be : 4'b0000;
            mem_wdata_d = is_store ? st_wdata : '0;
          end else begin
            state_d    = RESP;
            wb_valid_d = 1'b1;
            if (is_load || is_store) begin
              wb_err_d  = 1'b1;
              wb_data_d = '0;
            end else begin
              wb_data_d = alu_result;
              wb_we_d   = (rd != 5'd0) && (opcode != OPC_BRANCH);
            end
          end
        end
      end
      REQ: begin
        if (mem.mem_gnt) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          mem_be_d  = '0;
          cnt_d     = cnt_q + 16'd1;
          if (mem.mem_we) begin
            state_d    = RESP;
            wb_valid_d = 1'b1;
            wb_data_d  = '0;
          end else begin
            state_d = WAIT;
          end
        end else if (timeout_hit) begin
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          mem_be_d   = '0;
          state_d    = RESP;
          wb_valid_d = 1'b1;
          wb_err_d   = 1'b1;
          wb_data_d  = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      WAIT: begin
        if (mem.mem_rvalid) begin
          state_d    = RESP;
          wb_valid_d = 1'b1;
          wb_data_d  = ld_value;
          wb_we_d    = (wb_rd != 5'd0);
        end else if (timeout_hit) begin
          state_d    = RESP;
          wb_valid_d = 1'b1;
          wb_err_d   = 1'b1;
          wb_data_d  = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      addr_lo_q     <= '0;
      f3_q          <= '0;
      in_ready      <= 1'b1;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      mem.mem_be    <= '0;
      wb_valid      <= 1'b0;
      wb_we         <= 1'b0;
      wb_err        <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_lo_q     <= addr_lo_d;
      f3_q          <= f3_d;
      in_ready      <= in_ready_d;
      mem.mem_req   <= mem_req_d;
      mem.mem_we    <= mem_we_d;
      mem.mem_addr  <= mem_addr_d;
      mem.mem_wdata <= mem_wdata_d;
      mem.mem_be    <= mem_be_d;
      wb_valid      <= wb_valid_d;
      wb_we         <= wb_we_d;
      wb_err        <= wb_err_d;
      wb_rd         <= wb_rd_d;
      wb_data       <= wb_data_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit with a transaction-level reference model and memory responder.
module tb_load_store_unit;

  localparam int unsigned MT = 8;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] alu_result, store_data;
  logic        wb_valid, wb_we, wb_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int n_checks = 0;
  int n_errors = 0;

  load_store_unit_if mif ();

  load_store_unit #(.MEM_TIMEOUT(MT)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode     (opcode),
    .funct3     (funct3),
    .rd         (rd),
    .alu_result (alu_result),
    .store_data (store_data),
    .mem        (mif.master),
    .wb_valid   (wb_valid),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .wb_err     (wb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          access;
    bit          st;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          chk_data;
    logic        wb_we;
    logic        wb_err;
    logic [31:0] wb_data;
    int          lat;
    int          reqs;
  } exp_t;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: what one instruction should do, from opcode/width rules and the response timing.
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] r,
                                 input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdata,
                                 input int g, input int rv);
    exp_t e;
    bit is_ld, is_st, legal, mis;
    int unsigned b, h, size;
    logic [31:0] byte_v, half_v;
    e = '{default: '0};
    is_ld = (op == 7'h03);
    is_st = (op == 7'h23);
    legal = is_ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (is_st ? (f3 <= 3'd2) : 1'b1);
    size  = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
    mis   = (a % size) != 0;
    b     = a % 4;
    h     = (a / 2) % 2;
    if (!is_ld && !is_st) begin
      e.lat = 1; e.chk_data = 1; e.wb_data = a;
      e.wb_we = (r != 0) && (op != 7'h63);
    end else if (!legal || (TRAP && mis)) begin
      e.lat = 1; e.wb_err = 1;
    end else begin
      e.access = 1; e.st = is_st; e.addr = a - b;
      if (is_st) begin
        e.be    = (size == 1) ? 4'(1 << b) : ((size == 2) ? 4'(3 << (2 * h)) : 4'hF);
        e.wdata = (size == 1) ? (sd % 256) * 32'h0101_0101 :
                  ((size == 2) ? (sd % 65536) * 32'h0001_0001 : sd);
      end
      if (g + 1 > int'(MT)) begin
        e.reqs = MT; e.lat = MT + 1; e.wb_err = 1;
      end else if (is_ld && (g + rv + 1 > int'(MT))) begin
        e.reqs = g + 1; e.lat = MT + 1; e.wb_err = 1;
      end else begin
        e.reqs = g + 1;
        if (is_st) e.lat = 2 + g;
        else begin
          e.lat = 2 + g + rv;
          e.chk_data = 1;
          e.wb_we = (r != 0);
          byte_v = (rdata >> (8 * b)) % 256;
          half_v = (rdata >> (16 * h)) % 65536;
          case (f3)
            3'd0: e.wb_data = (byte_v >= 128) ? byte_v + 32'hFFFF_FF00 : byte_v;
            3'd1: e.wb_data = (half_v >= 32768) ? half_v + 32'hFFFF_0000 : half_v;
            3'd4: e.wb_data = byte_v;
            3'd5: e.wb_data = half_v;
            default: e.wb_data = rdata;
          endcase
        end
      end
    end
    return e;
  endfunction

  // Called and returns on a falling edge with the unit idle. g: cycles of gnt hold-off, rv: rvalid delay.
  task automatic do_op(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] r,
                       input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdata,
                       input int g, input int rv, output logic [31:0] got_data);
    exp_t e;
    int cyc, req_n, rv_left;
    bit got;
    e = model(op, f3, r, a, sd, rdata, g, rv);
    got_data = 'x;
    check_eq("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid = 1; opcode = op; funct3 = f3; rd = r; alu_result = a; store_data = sd;
    @(negedge clk);
    in_valid = 0;
    cyc = 1; req_n = 0; rv_left = 0; got = 0;
    while (!got && cyc <= 40) begin
      mif.mem_gnt = 0; mif.mem_rvalid = 0; mif.mem_rdata = $urandom;
      if (wb_valid) begin
        got = 1;
        got_data = wb_data;
        check_eq("latency", cyc, e.lat);
        check_eq("mem_req_cycles", req_n, e.reqs);
        check_eq("wb_we", {31'd0, wb_we}, {31'd0, e.wb_we});
        check_eq("wb_err", {31'd0, wb_err}, {31'd0, e.wb_err});
        check_eq("wb_rd", {27'd0, wb_rd}, {27'd0, r});
        check_eq("in_ready_resp", {31'd0, in_ready}, 32'd0);
        if (e.chk_data) check_eq("wb_data", wb_data, e.wb_data);
      end else begin
        if (mif.mem_req) begin
          check_eq("mem_access", {31'd0, e.access}, 32'd1);
          check_eq("mem_addr", mif.mem_addr, e.addr);
          check_eq("mem_we", {31'd0, mif.mem_we}, {31'd0, e.st});
          check_eq("mem_be", {28'd0, mif.mem_be}, {28'd0, e.be});
          if (e.st) check_eq("mem_wdata", mif.mem_wdata, e.wdata);
          if (req_n == g) begin
            mif.mem_gnt = 1;
            rv_left = rv;
            mif.mem_rvalid = 1'($urandom_range(0, 1));
          end
          req_n++;
        end else if (rv_left > 0) begin
          rv_left--;
          if (rv_left == 0) begin
            mif.mem_rvalid = 1;
            mif.mem_rdata = rdata;
          end
        end
        @(negedge clk);
        cyc++;
      end
    end
    if (!got) check_eq("wb_beat_seen", 32'd0, 32'd1);
    mif.mem_gnt = 0; mif.mem_rvalid = 0;
    @(negedge clk);
    check_eq("wb_one_beat", {31'd0, wb_valid}, 32'd0);
    check_eq("in_ready_after", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic stray_resp(input int n);
    for (int i = 0; i < n; i++) begin
      mif.mem_gnt = 1; mif.mem_rvalid = 1; mif.mem_rdata = $urandom;
      @(negedge clk);
      check_eq("stray_no_wb", {31'd0, wb_valid}, 32'd0);
      check_eq("stray_no_req", {31'd0, mif.mem_req}, 32'd0);
    end
    mif.mem_gnt = 0; mif.mem_rvalid = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [6:0]  ops [7];
    logic [6:0]  op;
    int          kind, g, rv;
    ops = '{7'h13, 7'h33, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63};
    rst = 1; in_valid = 0; opcode = '0; funct3 = '0; rd = '0; alu_result = '0; store_data = '0;
    mif.mem_gnt = 0; mif.mem_rvalid = 0; mif.mem_rdata = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_mem_req", {31'd0, mif.mem_req}, 32'd0);
    check_eq("rst_mem_we", {31'd0, mif.mem_we}, 32'd0);
    check_eq("rst_mem_be", {28'd0, mif.mem_be}, 32'd0);
    check_eq("rst_mem_addr", mif.mem_addr, 32'd0);
    check_eq("rst_mem_wdata", mif.mem_wdata, 32'd0);
    check_eq("rst_wb", {29'd0, wb_valid, wb_we, wb_err}, 32'd0);
    check_eq("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    check_eq("rst_wb_data", wb_data, 32'd0);
    rst = 0;
    @(negedge clk);

    do_op(7'h13, 3'd0, 5'd5, 32'h1234, 32'h0, 32'h0, 0, 1, d);
    check_eq("t1_addi", d, 32'h0000_1234);
    do_op(7'h03, 3'd0, 5'd3, 32'h103, 32'h0, 32'h80FF_0000, 0, 1, d);
    check_eq("t2_lb", d, 32'hFFFF_FF80);
    do_op(7'h03, 3'd4, 5'd3, 32'h103, 32'h0, 32'h80FF_0000, 0, 1, d);
    check_eq("t2_lbu", d, 32'h0000_0080);
    do_op(7'h23, 3'd1, 5'd0, 32'h202, 32'hABCD, 32'h0, 4, 1, d);
    do_op(7'h03, 3'd2, 5'd9, 32'h40, 32'h0, 32'h0, 99, 1, d);
    stray_resp(3);
    do_op(7'h03, 3'd2, 5'd9, 32'h44, 32'h0, 32'h0, 0, 99, d);
    stray_resp(2);
    do_op(7'h03, 3'd2, 5'd4, 32'h2, 32'h0, 32'hCAFE_F00D, 0, 1, d);
    do_op(7'h03, 3'd3, 5'd4, 32'h8, 32'h0, 32'h0, 0, 1, d);
    do_op(7'h23, 3'd3, 5'd4, 32'h8, 32'h0, 32'h0, 0, 1, d);
    do_op(7'h63, 3'd0, 5'd6, 32'h77, 32'h0, 32'h0, 0, 1, d);
    do_op(7'h13, 3'd0, 5'd0, 32'h55, 32'h0, 32'h0, 0, 1, d);

    // Reset while waiting for read data: the late rvalid must not produce a beat.
    in_valid = 1; opcode = 7'h03; funct3 = 3'd2; rd = 5'd7; alu_result = 32'h10;
    @(negedge clk);
    in_valid = 0;
    check_eq("rw_mem_req", {31'd0, mif.mem_req}, 32'd1);
    mif.mem_gnt = 1;
    @(negedge clk);
    mif.mem_gnt = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    check_eq("rw_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rw_mem_req_off", {31'd0, mif.mem_req}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      mif.mem_rvalid = 1; mif.mem_rdata = $urandom;
      @(negedge clk);
      check_eq("rw_no_wb", {31'd0, wb_valid}, 32'd0);
    end
    mif.mem_rvalid = 0;

    // Accept coinciding with reset: nothing captured.
    in_valid = 1; opcode = 7'h13; funct3 = 3'd0; rd = 5'd7; alu_result = 32'hDEAD;
    rst = 1;
    @(negedge clk);
    in_valid = 0; rst = 0;
    check_eq("ar_no_wb", {31'd0, wb_valid}, 32'd0);
    check_eq("ar_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("ar_wb_rd", {27'd0, wb_rd}, 32'd0);

    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 2);
      op = (kind == 0) ? ops[$urandom_range(0, 6)] : ((kind == 1) ? 7'h03 : 7'h23);
      g  = ($urandom_range(0, 11) == 0) ? 99 : $urandom_range(0, 3);
      rv = $urandom_range(1, 3);
      do_op(op, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), $urandom, $urandom,
            $urandom, g, rv, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
